// File: rtl/xintf_arbiter.sv
// Two-requester round-robin arbiter driving an XINTF-style external bus.
// Each bus cycle runs SETUP -> ACTIVE -> HOLD -> ACK, then returns to IDLE.
// Optional macro XINTF_ARB_READY_EN: ACTIVE stretches while xready is low
// once its minimum length has elapsed. Without it, xready is ignored.
module xintf_arbiter #(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned ACTIVE_CYC = 3,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [16:0] addr0,
    input  logic [16:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    input  logic        we0,
    input  logic        we1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] rdata,
    output logic        busy,
    output logic [15:0] xa,
    output logic [15:0] xd_out,
    output logic        xd_oe,
    input  logic [15:0] xd_in,
    output logic        xwen,
    output logic        xrdn,
    output logic        zone_6_n,
    output logic        zone_7_n,
    input  logic        xready
);

    localparam logic [3:0] SetupLast  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] ActiveLast = 4'(ACTIVE_CYC - 1);
    localparam logic [3:0] HoldLast   = 4'(HOLD_CYC - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StActive, StHold, StAck} state_e;

    state_e     state;
    logic [3:0] cnt;
    logic       cur_we;
    logic       cur_id;
    logic       last_id;
    logic       grant_id;
    logic       active_exit;

    // Round-robin pick: on contention the requester not served last wins.
    always_comb begin
        grant_id = (req0 && req1) ? ~last_id : req1;
    end

`ifdef XINTF_ARB_READY_EN
    assign active_exit = (cnt == ActiveLast) && xready;
`else
    logic unused_xready;
    assign unused_xready = xready;
    assign active_exit   = (cnt == ActiveLast);
`endif

    // Bus-cycle sequencer with all XINTF outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= StIdle;
            cnt      <= 4'd0;
            cur_we   <= 1'b0;
            cur_id   <= 1'b0;
            last_id  <= 1'b1;  // so requester 0 wins the first contention
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rdata    <= 16'h0000;
            busy     <= 1'b0;
            xa       <= 16'h0000;
            xd_out   <= 16'h0000;
            xd_oe    <= 1'b0;
            xwen     <= 1'b1;
            xrdn     <= 1'b1;
            zone_6_n <= 1'b1;
            zone_7_n <= 1'b1;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (req0 || req1) begin
                        state   <= StSetup;
                        cnt     <= 4'd0;
                        busy    <= 1'b1;
                        cur_id  <= grant_id;
                        last_id <= grant_id;
                        if (grant_id) begin
                            xa       <= addr1[15:0];
                            zone_6_n <= addr1[16];
                            zone_7_n <= ~addr1[16];
                            cur_we   <= we1;
                            xd_oe    <= we1;
                            if (we1) xd_out <= wdata1;
                        end else begin
                            xa       <= addr0[15:0];
                            zone_6_n <= addr0[16];
                            zone_7_n <= ~addr0[16];
                            cur_we   <= we0;
                            xd_oe    <= we0;
                            if (we0) xd_out <= wdata0;
                        end
                    end
                end
                StSetup: begin
                    if (cnt == SetupLast) begin
                        state <= StActive;
                        cnt   <= 4'd0;
                        if (cur_we) xwen <= 1'b0;
                        else        xrdn <= 1'b0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                StActive: begin
                    if (active_exit) begin
                        state <= StHold;
                        cnt   <= 4'd0;
                        xwen  <= 1'b1;
                        xrdn  <= 1'b1;
                        if (!cur_we) rdata <= xd_in;
                    end else if (cnt != ActiveLast) begin
                        cnt <= cnt + 4'd1;
                    end
                end
                StHold: begin
                    if (cnt == HoldLast) begin
                        state    <= StAck;
                        zone_6_n <= 1'b1;
                        zone_7_n <= 1'b1;
                        xd_oe    <= 1'b0;
                        if (cur_id) ack1 <= 1'b1;
                        else        ack0 <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                StAck: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_xintf_arbiter.sv
// Directed bench for xintf_arbiter (default timing 2/3/1). Honours
// XINTF_ARB_READY_EN when it is defined for the build.
module tb_xintf_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1, xready;
    logic [16:0] addr0, addr1;
    logic [15:0] wdata0, wdata1, xd_in;
    logic        ack0, ack1, busy, xd_oe, xwen, xrdn, zone_6_n, zone_7_n;
    logic [15:0] rdata, xa, xd_out;

    always #5 clk = ~clk;

    xintf_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .xa(xa), .xd_out(xd_out), .xd_oe(xd_oe), .xd_in(xd_in),
        .xwen(xwen), .xrdn(xrdn), .zone_6_n(zone_6_n), .zone_7_n(zone_7_n),
        .xready(xready)
    );

`ifdef XINTF_ARB_READY_EN
    localparam int RdyLow = 7, RdyAck = 10;
    localparam logic [15:0] RdyData = 16'hA008;
`else
    localparam int RdyLow = 3, RdyAck = 6;
    localparam logic [15:0] RdyData = 16'hA004;
`endif

    int vectors = 0, miscompares = 0;
    int z6, z7, wl, rl, nack, bad, busy_low, strobe_bad;
    int ack_id[8], ack_at[8];
    logic [15:0] rd_at_ack, exp_xa, exp_wd;
    bit chk_strobe;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Samples ncyc cycles starting at the current one; drops req on ack unless keep.
    task automatic measure(input int ncyc, input bit keep, input bit rdy_test);
        z6 = 0; z7 = 0; wl = 0; rl = 0; nack = 0; bad = 0; busy_low = 0; strobe_bad = 0;
        for (int k = 0; k < 8; k++) begin ack_id[k] = -1; ack_at[k] = -1; end
        for (int i = 0; i < ncyc; i++) begin
            if (rdy_test) begin
                xready = !(i >= 4 && i <= 7);
                xd_in  = 16'hA000 + 16'(i);
            end
            if (!zone_6_n) z6++;
            if (!zone_7_n) z7++;
            if (!xwen) wl++;
            if (!xrdn) rl++;
            if (!busy) busy_low++;
            if ((!xwen && !xrdn) || (!zone_6_n && !zone_7_n) || (ack0 && ack1)) bad++;
            if (chk_strobe && (!xwen || !xrdn)) begin
                if (xa !== exp_xa) strobe_bad++;
                if (!xwen && (xd_oe !== 1'b1 || xd_out !== exp_wd)) strobe_bad++;
            end
            if (ack0 || ack1) begin
                if (nack < 8) begin
                    ack_id[nack] = ack1 ? 1 : 0;
                    ack_at[nack] = i;
                end
                nack++;
                rd_at_ack = rdata;
                if (!keep) begin
                    if (ack0) req0 = 1'b0;
                    if (ack1) req1 = 1'b0;
                end
            end
            tick();
        end
        xready = 1'b1;
    endtask

    initial begin
        reset = 1'b0; req0 = 0; req1 = 0; we0 = 0; we1 = 0; xready = 1'b1;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; xd_in = '0;
        chk_strobe = 0; exp_xa = '0; exp_wd = '0;
        tick(); tick();
        // Reset values
        check("rst_xa", xa, 0);
        check("rst_xd_out", xd_out, 0);
        check("rst_xd_oe", xd_oe, 0);
        check("rst_xwen", xwen, 1);
        check("rst_xrdn", xrdn, 1);
        check("rst_zone6", zone_6_n, 1);
        check("rst_zone7", zone_7_n, 1);
        check("rst_ack", {ack1, ack0}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        tick();

        // Write from requester 0 into zone 6
        req0 = 1; we0 = 1; addr0 = 17'h01000; wdata0 = 16'h0AA0;
        tick();
        check("wr_setup_zone6", zone_6_n, 0);
        check("wr_setup_xd_oe", xd_oe, 1);
        check("wr_setup_busy", busy, 1);
        check("wr_setup_xwen", xwen, 1);
        chk_strobe = 1; exp_xa = 16'h1000; exp_wd = 16'h0AA0;
        measure(8, 0, 0);
        check("wr_zone6_low", z6, 6);
        check("wr_zone7_low", z7, 0);
        check("wr_xwen_low", wl, 3);
        check("wr_xrdn_low", rl, 0);
        check("wr_strobe_data", strobe_bad, 0);
        check("wr_ack0_at", ack_at[0], 6);
        check("wr_ack_id", ack_id[0], 0);
        check("wr_nack", nack, 1);
        check("wr_idle_busy", busy, 0);

        // Read from requester 1 in zone 7
        req1 = 1; we1 = 0; addr1 = 17'h11000; xd_in = 16'hBEEF;
        tick();
        exp_xa = 16'h1000;
        measure(8, 0, 0);
        check("rd_zone7_low", z7, 6);
        check("rd_zone6_low", z6, 0);
        check("rd_xrdn_low", rl, 3);
        check("rd_xwen_low", wl, 0);
        check("rd_xa", strobe_bad, 0);
        check("rd_ack1_at", ack_at[0], 6);
        check("rd_ack_id", ack_id[0], 1);
        check("rd_rdata_at_ack", rd_at_ack, 16'hBEEF);
        xd_in = 16'h1234;
        tick(); tick();
        check("rd_rdata_held", rdata, 16'hBEEF);
        chk_strobe = 0;

        // Both requesting and holding: four alternating transfers
        req0 = 1; we0 = 1; addr0 = 17'h00010; wdata0 = 16'h1111;
        req1 = 1; we1 = 0; addr1 = 17'h10020; xd_in = 16'h2222;
        tick();
        measure(31, 1, 0);
        req0 = 0; req1 = 0;
        check("rr_nack", nack, 4);
        check("rr_ids", {ack_id[0][3:0], ack_id[1][3:0], ack_id[2][3:0], ack_id[3][3:0]},
              32'h0101);
        check("rr_at", {ack_at[0][7:0], ack_at[1][7:0], ack_at[2][7:0], ack_at[3][7:0]},
              {8'd6, 8'd14, 8'd22, 8'd30});
        check("rr_exclusive", bad, 0);
        check("rr_idle_gaps", busy_low, 3);
        check("rr_rdata", rdata, 16'h2222);
        tick();

        // req0 dropped during SETUP: cycle still completes, no follow-up
        req0 = 1; we0 = 1; addr0 = 17'h00044; wdata0 = 16'h5555;
        tick();
        req0 = 0;
        measure(12, 0, 0);
        check("drop_nack", nack, 1);
        check("drop_ack0_at", ack_at[0], 6);
        check("drop_zone6_low", z6, 6);

        // Reset pulse in the middle of ACTIVE of a write
        req0 = 1; we0 = 1; addr0 = 17'h00030; wdata0 = 16'h3333;
        tick(); tick(); tick(); tick();
        check("rst_mid_pre_xwen", xwen, 0);
        reset = 1'b0;
        #1;
        check("rst_mid_xwen", xwen, 1);
        check("rst_mid_zone6", zone_6_n, 1);
        check("rst_mid_busy", busy, 0);
        req0 = 0;
        tick(); tick();
        check("rst_mid_no_ack", {ack1, ack0}, 0);
        reset = 1'b1;
        tick();
        req0 = 1; req1 = 1; we1 = 0; addr1 = 17'h10040; xd_in = 16'h4444;
        tick();
        measure(16, 0, 0);
        check("post_rst_nack", nack, 2);
        check("post_rst_first", ack_id[0], 0);
        check("post_rst_second", ack_id[1], 1);
        check("post_rst_at", {ack_at[0][7:0], ack_at[1][7:0]}, {8'd6, 8'd14});

        // Read with xready held low for four cycles past the minimum ACTIVE
        req1 = 1; we1 = 0; addr1 = 17'h10050;
        tick();
        measure(14, 0, 1);
        check("rdy_xrdn_low", rl, RdyLow);
        check("rdy_ack_at", ack_at[0], RdyAck);
        check("rdy_rdata", rd_at_ack, RdyData);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/xintf_arbiter.md
XINTF_ARBITER -- requirements
Module: xintf_arbiter

Interface
REQ-001 Parameter SETUP_CYC, default 2, XINTF lead/setup phase length in clk cycles (legal 1..15).
REQ-002 Parameter ACTIVE_CYC, default 3, strobe-low phase length in clk cycles (legal 1..15).
REQ-003 Parameter HOLD_CYC, default 1, trail/hold phase length in clk cycles (legal 1..15).
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req0, req1  input  1 each  requester bus-cycle request, held until matching ack.
REQ-007 addr0, addr1  input  17 each  [15:0] bus address; [16] zone select (0 = zone 6, 1 = zone 7).
REQ-008 wdata0, wdata1  input  16 each  write data.
REQ-009 we0, we1  input  1 each  1 = write, 0 = read.
REQ-010 ack0, ack1  output  1 each  one-cycle completion pulse.
REQ-011 rdata  output  16  read data, valid in the ack cycle.
REQ-012 busy  output  1  high from grant until the ack cycle inclusive.
REQ-013 xa  output  16; xd_out  output  16; xd_oe  output  1; xd_in  input  16  XINTF address/data (xd tri-state resolved outside).
REQ-014 xwen, xrdn, zone_6_n, zone_7_n  output  1 each  active-low XINTF strobes and chip selects.
REQ-015 xready  input  1  external wait-state ready (used only when XINTF_ARB_READY_EN is defined).

Function
REQ-016 The block SHALL have states IDLE, SETUP, ACTIVE, HOLD, ACK.
REQ-017 In IDLE with any req high, the block SHALL latch the winner's addr/wdata/we and move to SETUP on the next edge.
REQ-018 Arbitration SHALL be round-robin: with both requesting, the requester not most recently served wins; a lone requester always wins.
REQ-019 SETUP SHALL last SETUP_CYC cycles: selected zone_n low, xa = addr[15:0], for writes xd_oe = 1 and xd_out = wdata.
REQ-020 ACTIVE SHALL last ACTIVE_CYC cycles with xwen low (write) or xrdn low (read); other strobe high.
REQ-021 For reads, xd_in SHALL be registered on the last ACTIVE cycle and held on rdata until the next read completes.
REQ-022 HOLD SHALL last HOLD_CYC cycles: strobes high, zone_n, xa, xd_out, xd_oe unchanged.
REQ-023 ACK SHALL last exactly one cycle: ackN of the served requester high, zone_n high, xd_oe low; then IDLE.
REQ-024 At most one ack SHALL be high in any cycle; only one zone_n SHALL be low at a time.
REQ-025 Latency: first SETUP cycle one cycle after req sampled in IDLE; ack at SETUP_CYC+ACTIVE_CYC+HOLD_CYC cycles after first SETUP cycle.
REQ-026 A new grant SHALL not occur in the ACK cycle; minimum one IDLE cycle between bus cycles.
REQ-027 Deassertion of req or changes to addr/wdata/we after grant SHALL not affect the running cycle; ack is still issued.
REQ-028 A requester still holding req in the cycle after its ack SHALL be treated as a new request.

Reset
REQ-029 reset low SHALL immediately force IDLE, abandoning any cycle in progress.
REQ-030 Reset values: xa = 0, xd_out = 0, xd_oe = 0, xwen = 1, xrdn = 1, zone_6_n = 1, zone_7_n = 1, ack0 = ack1 = 0, rdata = 0, busy = 0.
REQ-031 After reset the round-robin pointer SHALL favour requester 0.

Configuration
REQ-032 Macro XINTF_ARB_READY_EN defined: after ACTIVE_CYC cycles, ACTIVE SHALL extend while xready is low; rdata captured in the last ACTIVE cycle, the first cycle with xready high.
REQ-033 Macro XINTF_ARB_READY_EN undefined: xready SHALL be ignored and ACTIVE is exactly ACTIVE_CYC cycles.

Verification
REQ-034 Write req0, addr0 = 0x01000, wdata0 = 0x0AA0 -> zone_6_n low 6 cycles, xwen low 3 cycles with xd_out = 0x0AA0 and xd_oe = 1, ack0 pulse 6 cycles after first SETUP cycle.
REQ-035 Read req1, addr1 = 0x11000, xd_in = 0xBEEF -> zone_7_n low, xrdn low 3 cycles, xa = 0x1000, rdata = 0xBEEF with ack1.
REQ-036 req0 and req1 asserted same cycle, held through 4 transfers -> grants alternate 0,1,0,1; never two acks together; one IDLE cycle between bus cycles.
REQ-037 reset pulsed low during ACTIVE of a write -> xwen, zone_n return high immediately, no ack, next request served normally from requester 0 priority.
REQ-038 XINTF_ARB_READY_EN defined, xready low 4 extra cycles during a read -> xrdn low 7 cycles, rdata captured when xready rises; undefined -> xrdn low 3 cycles regardless.
REQ-039 req0 dropped in SETUP -> cycle completes, ack0 pulses, no further cycle started.
